// File: rtl/axis_arb_pkg.sv
// Shared types and defaults for the packet-atomic AXI-Stream arbiter.
package axis_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PASS = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_SRC = 4;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ID_W    = 8;
    localparam int DEF_DEST_W  = 8;
    localparam int DEF_USER_W  = 1;
    localparam int DEF_CNT_W   = 16;

    // Index width for n sources; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_packet_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after 'last', wrapping modulo NUM_SRC.
module rr_pick
    import axis_arb_pkg::*;
#(
    parameter  int NUM_SRC = DEF_NUM_SRC,
    localparam int IDX_W   = idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand     = (int'(last) + k) % NUM_SRC;
            cand_idx = IDX_W'(cand);
            if (!any && req[cand_idx]) begin
                any = 1'b1;
                idx = cand_idx;
            end
        end
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-atomic round-robin arbiter sharing one AXI-Stream sink among NUM_SRC sources.
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int NUM_SRC = DEF_NUM_SRC,
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int ID_W    = DEF_ID_W,
    parameter  int DEST_W  = DEF_DEST_W,
    parameter  int USER_W  = DEF_USER_W,
    parameter  int CNT_W   = DEF_CNT_W,
    localparam int KEEP_W  = DATA_W / 8,
    localparam int IDX_W   = idx_w(NUM_SRC)
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [NUM_SRC-1:0]         s_tvalid,
    output logic [NUM_SRC-1:0]         s_tready,
    input  logic [NUM_SRC*DATA_W-1:0]  s_tdata,
    input  logic [NUM_SRC*KEEP_W-1:0]  s_tkeep,
    input  logic [NUM_SRC*KEEP_W-1:0]  s_tstrb,
    input  logic [NUM_SRC-1:0]         s_tlast,
    input  logic [NUM_SRC*ID_W-1:0]    s_tid,
    input  logic [NUM_SRC*DEST_W-1:0]  s_tdest,
    input  logic [NUM_SRC*USER_W-1:0]  s_tuser,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [DATA_W-1:0]          m_tdata,
    output logic [KEEP_W-1:0]          m_tkeep,
    output logic [KEEP_W-1:0]          m_tstrb,
    output logic                       m_tlast,
    output logic [ID_W-1:0]            m_tid,
    output logic [DEST_W-1:0]          m_tdest,
    output logic [USER_W-1:0]          m_tuser,
    output logic                       grant_valid,
    output logic [IDX_W-1:0]           grant_idx,
    output logic [CNT_W-1:0]           last_pkt_beats,
    output logic                       pkt_done
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] rr_last_q, rr_last_d;
    logic             grant_valid_q, grant_valid_d;
    logic             pkt_done_q, pkt_done_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] last_pkt_beats_q, last_pkt_beats_d;
    logic [CNT_W-1:0] beat_inc;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             m_hs;

    rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req  (s_tvalid),
        .last (rr_last_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Payload follows the registered owner; valid/ready only open while passing a packet.
    always_comb begin
        m_tvalid = 1'b0;
        s_tready = '0;
        m_tdata  = s_tdata[grant_idx_q*DATA_W +: DATA_W];
        m_tkeep  = s_tkeep[grant_idx_q*KEEP_W +: KEEP_W];
        m_tstrb  = s_tstrb[grant_idx_q*KEEP_W +: KEEP_W];
        m_tlast  = s_tlast[grant_idx_q];
        m_tid    = s_tid[grant_idx_q*ID_W +: ID_W];
        m_tdest  = s_tdest[grant_idx_q*DEST_W +: DEST_W];
        m_tuser  = s_tuser[grant_idx_q*USER_W +: USER_W];
        if (state_q == PASS) begin
            m_tvalid              = s_tvalid[grant_idx_q];
            s_tready[grant_idx_q] = m_tready;
        end
    end

    assign m_hs     = m_tvalid & m_tready;
    assign beat_inc = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + 1'b1;

    always_comb begin
        state_d          = state_q;
        grant_idx_d      = grant_idx_q;
        grant_valid_d    = grant_valid_q;
        rr_last_d        = rr_last_q;
        beat_cnt_d       = beat_cnt_q;
        last_pkt_beats_d = last_pkt_beats_q;
        pkt_done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_idx_d   = pick_idx;
                    grant_valid_d = 1'b1;
                    state_d       = PASS;
                end
            end
            PASS: begin
                if (m_hs) begin
                    if (m_tlast) begin
                        last_pkt_beats_d = beat_inc;
                        pkt_done_d       = 1'b1;
                        beat_cnt_d       = '0;
                        rr_last_d        = grant_idx_q;
                        grant_valid_d    = 1'b0;
                        state_d          = IDLE;
                    end else begin
                        beat_cnt_d = beat_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // rr_last resets to the top index so the first search after reset starts at source 0.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q          <= IDLE;
            grant_idx_q      <= '0;
            grant_valid_q    <= 1'b0;
            rr_last_q        <= IDX_W'(NUM_SRC - 1);
            beat_cnt_q       <= '0;
            last_pkt_beats_q <= '0;
            pkt_done_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            grant_idx_q      <= grant_idx_d;
            grant_valid_q    <= grant_valid_d;
            rr_last_q        <= rr_last_d;
            beat_cnt_q       <= beat_cnt_d;
            last_pkt_beats_q <= last_pkt_beats_d;
            pkt_done_q       <= pkt_done_d;
        end
    end

    assign grant_valid    = grant_valid_q;
    assign grant_idx      = grant_idx_q;
    assign last_pkt_beats = last_pkt_beats_q;
    assign pkt_done       = pkt_done_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed self-checking bench for axis_packet_arbiter (4 sources, 32-bit data).
module tb_axis_packet_arbiter;

    logic         aclk;
    logic         aresetn;
    logic [3:0]   s_tvalid, s_tready, s_tlast, s_tuser;
    logic [127:0] s_tdata;
    logic [15:0]  s_tkeep, s_tstrb;
    logic [31:0]  s_tid, s_tdest;
    logic         m_tvalid, m_tready, m_tlast;
    logic [31:0]  m_tdata;
    logic [3:0]   m_tkeep, m_tstrb;
    logic [7:0]   m_tid, m_tdest;
    logic [0:0]   m_tuser;
    logic         grant_valid, pkt_done;
    logic [1:0]   grant_idx;
    logic [15:0]  last_pkt_beats;

    int n_checks = 0;
    int n_pass   = 0;

    axis_packet_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tstrb(s_tstrb), .s_tlast(s_tlast),
        .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tstrb(m_tstrb), .m_tlast(m_tlast),
        .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
        .grant_valid(grant_valid), .grant_idx(grant_idx),
        .last_pkt_beats(last_pkt_beats), .pkt_done(pkt_done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic mid();
        @(negedge aclk);
    endtask

    task automatic drive(input int i, input logic v, input logic [31:0] d, input logic l);
        s_tvalid[i]          = v;
        s_tdata[i*32 +: 32]  = d;
        s_tlast[i]           = l;
    endtask

    function automatic logic [31:0] rr_word(input int s, input int p, input int b);
        return 32'(s * 256 + p * 16 + b);
    endfunction

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) step();
        aresetn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            mid();
            n_checks++;
            if ({m_tvalid, s_tready, grant_valid, pkt_done} !== 7'b0) begin
                $display("[TB] FAIL reset_idle cyc%0d: got %b expected %b", c,
                         {m_tvalid, s_tready, grant_valid, pkt_done}, 7'b0);
            end else n_pass++;
            step();
        end
        mid();
        n_checks++;
        if ({grant_idx, last_pkt_beats} !== 18'h0) begin
            $display("[TB] FAIL reset_regs: got %h expected %h", {grant_idx, last_pkt_beats}, 18'h0);
        end else n_pass++;
        step();
    endtask

    task automatic test_single_packet();
        logic [31:0] exp_d;
        drive(0, 1'b1, 32'h42, 1'b0);
        mid();
        n_checks++;
        if ({grant_valid, m_tvalid} !== 2'b00) begin
            $display("[TB] FAIL sp_bubble: got %b expected 00", {grant_valid, m_tvalid});
        end else n_pass++;
        step();
        for (int b = 0; b < 4; b++) begin
            mid();
            exp_d = 32'h42 + 32'(b);
            n_checks++;
            if ({grant_valid, grant_idx, m_tvalid, s_tready, m_tlast} !== {1'b1, 2'd0, 1'b1, 4'b0001, (b == 3)}) begin
                $display("[TB] FAIL sp_ctrl beat%0d: got %b expected %b", b,
                         {grant_valid, grant_idx, m_tvalid, s_tready, m_tlast},
                         {1'b1, 2'd0, 1'b1, 4'b0001, (b == 3)});
            end else n_pass++;
            n_checks++;
            if (m_tdata !== exp_d) begin
                $display("[TB] FAIL sp_data beat%0d: got %h expected %h", b, m_tdata, exp_d);
            end else n_pass++;
            step();
            if (b < 3) drive(0, 1'b1, 32'h43 + 32'(b), (b == 2));
            else       drive(0, 1'b0, 32'h0, 1'b0);
        end
        mid();
        n_checks++;
        if ({pkt_done, grant_valid, last_pkt_beats} !== {1'b1, 1'b0, 16'd4}) begin
            $display("[TB] FAIL sp_done: got %h expected %h", {pkt_done, grant_valid, last_pkt_beats},
                     {1'b1, 1'b0, 16'd4});
        end else n_pass++;
        step();
        mid();
        n_checks++;
        if (pkt_done !== 1'b0) begin
            $display("[TB] FAIL sp_pulse_width: got %b expected 0", pkt_done);
        end else n_pass++;
        step();
    endtask

    task automatic test_round_robin();
        int          beat[4];
        int          pkt[4];
        int          order[$];
        int          exp_order[4];
        logic [31:0] exp_words[8];
        logic        prev_gv;
        logic [3:0]  hs;
        int          hs_total;
        exp_order = '{0, 1, 3, 0};
        exp_words = '{rr_word(0,0,0), rr_word(0,0,1), rr_word(1,0,0), rr_word(1,0,1),
                      rr_word(3,0,0), rr_word(3,0,1), rr_word(0,1,0), rr_word(0,1,1)};
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin beat[i] = 0; pkt[i] = 0; end
        prev_gv  = 1'b0;
        hs_total = 0;
        drive(0, 1'b1, rr_word(0,0,0), 1'b0);
        drive(1, 1'b1, rr_word(1,0,0), 1'b0);
        drive(3, 1'b1, rr_word(3,0,0), 1'b0);
        for (int cyc = 0; cyc < 60 && hs_total < 8; cyc++) begin
            mid();
            if (grant_valid && !prev_gv) order.push_back(int'(grant_idx));
            prev_gv = grant_valid;
            hs = s_tvalid & s_tready;
            if (m_tvalid && m_tready) begin
                n_checks++;
                if (m_tdata !== exp_words[hs_total]) begin
                    $display("[TB] FAIL rr_word%0d: got %h expected %h", hs_total, m_tdata, exp_words[hs_total]);
                end else n_pass++;
                hs_total++;
            end
            step();
            for (int i = 0; i < 4; i++) begin
                if (hs[i]) begin
                    beat[i]++;
                    if (beat[i] == 2) begin
                        if (i == 0 && pkt[0] == 0) begin
                            pkt[0]  = 1;
                            beat[0] = 0;
                            drive(0, 1'b1, rr_word(0,1,0), 1'b0);
                        end else begin
                            drive(i, 1'b0, 32'h0, 1'b0);
                        end
                    end else begin
                        drive(i, 1'b1, rr_word(i, pkt[i], beat[i]), (beat[i] == 1));
                    end
                end
            end
        end
        s_tvalid = '0;
        n_checks++;
        if (hs_total !== 8) begin
            $display("[TB] FAIL rr_beats: got %0d expected 8", hs_total);
        end else n_pass++;
        n_checks++;
        if (order.size() !== 4) begin
            $display("[TB] FAIL rr_grant_count: got %0d expected 4", order.size());
        end else n_pass++;
        for (int k = 0; k < 4 && k < order.size(); k++) begin
            n_checks++;
            if (order[k] !== exp_order[k]) begin
                $display("[TB] FAIL rr_order%0d: got %0d expected %0d", k, order[k], exp_order[k]);
            end else n_pass++;
        end
        step();
        step();
    endtask

    task automatic test_backpressure();
        m_tready = 1'b1;
        drive(2, 1'b1, 32'hDEADBEEF, 1'b0);
        mid();
        n_checks++;
        if (grant_valid !== 1'b0) begin
            $display("[TB] FAIL bp_bubble: got %b expected 0", grant_valid);
        end else n_pass++;
        step();
        mid();
        n_checks++;
        if ({grant_valid, grant_idx, m_tdata, m_tid, m_tdest, m_tuser} !==
            {1'b1, 2'd2, 32'hDEADBEEF, 8'h02, 8'hD2, 1'b1}) begin
            $display("[TB] FAIL bp_first: got %h expected %h",
                     {grant_valid, grant_idx, m_tdata, m_tid, m_tdest, m_tuser},
                     {1'b1, 2'd2, 32'hDEADBEEF, 8'h02, 8'hD2, 1'b1});
        end else n_pass++;
        step();
        drive(2, 1'b1, 32'h1, 1'b0);
        m_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            mid();
            n_checks++;
            if ({grant_valid, grant_idx, m_tvalid, s_tready, m_tdata} !== {1'b1, 2'd2, 1'b1, 4'b0000, 32'h1}) begin
                $display("[TB] FAIL bp_stall cyc%0d: got %h expected %h", c,
                         {grant_valid, grant_idx, m_tvalid, s_tready, m_tdata},
                         {1'b1, 2'd2, 1'b1, 4'b0000, 32'h1});
            end else n_pass++;
            step();
        end
        m_tready = 1'b1;
        mid();
        n_checks++;
        if (s_tready !== 4'b0100) begin
            $display("[TB] FAIL bp_release: got %b expected 0100", s_tready);
        end else n_pass++;
        step();
        drive(2, 1'b1, 32'h2, 1'b1);
        mid();
        n_checks++;
        if ({m_tdata, m_tlast} !== {32'h2, 1'b1}) begin
            $display("[TB] FAIL bp_last: got %h expected %h", {m_tdata, m_tlast}, {32'h2, 1'b1});
        end else n_pass++;
        step();
        drive(2, 1'b0, 32'h0, 1'b0);
        mid();
        n_checks++;
        if ({pkt_done, last_pkt_beats} !== {1'b1, 16'd3}) begin
            $display("[TB] FAIL bp_count: got %h expected %h", {pkt_done, last_pkt_beats}, {1'b1, 16'd3});
        end else n_pass++;
        step();
    endtask

    task automatic test_valid_gap();
        drive(1, 1'b1, 32'h100, 1'b0);
        mid();
        step();
        mid();
        n_checks++;
        if ({grant_valid, grant_idx, m_tdata} !== {1'b1, 2'd1, 32'h100}) begin
            $display("[TB] FAIL gap_first: got %h expected %h", {grant_valid, grant_idx, m_tdata},
                     {1'b1, 2'd1, 32'h100});
        end else n_pass++;
        step();
        drive(1, 1'b0, 32'h0, 1'b0);
        drive(0, 1'b1, 32'hA0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            mid();
            n_checks++;
            if ({grant_valid, grant_idx, m_tvalid, s_tready} !== {1'b1, 2'd1, 1'b0, 4'b0010}) begin
                $display("[TB] FAIL gap_hold cyc%0d: got %b expected %b", c,
                         {grant_valid, grant_idx, m_tvalid, s_tready}, {1'b1, 2'd1, 1'b0, 4'b0010});
            end else n_pass++;
            step();
        end
        for (int b = 1; b < 3; b++) begin
            drive(1, 1'b1, 32'h100 + 32'(b), (b == 2));
            mid();
            n_checks++;
            if ({grant_idx, m_tvalid, m_tdata} !== {2'd1, 1'b1, 32'h100 + 32'(b)}) begin
                $display("[TB] FAIL gap_beat%0d: got %h expected %h", b, {grant_idx, m_tvalid, m_tdata},
                         {2'd1, 1'b1, 32'h100 + 32'(b)});
            end else n_pass++;
            step();
        end
        drive(1, 1'b0, 32'h0, 1'b0);
        mid();
        n_checks++;
        if ({pkt_done, grant_valid, last_pkt_beats} !== {1'b1, 1'b0, 16'd3}) begin
            $display("[TB] FAIL gap_done: got %h expected %h", {pkt_done, grant_valid, last_pkt_beats},
                     {1'b1, 1'b0, 16'd3});
        end else n_pass++;
        step();
        mid();
        n_checks++;
        if ({grant_valid, grant_idx, m_tdata, m_tlast} !== {1'b1, 2'd0, 32'hA0, 1'b1}) begin
            $display("[TB] FAIL gap_next_owner: got %h expected %h", {grant_valid, grant_idx, m_tdata, m_tlast},
                     {1'b1, 2'd0, 32'hA0, 1'b1});
        end else n_pass++;
        step();
        drive(0, 1'b0, 32'h0, 1'b0);
        mid();
        n_checks++;
        if ({pkt_done, last_pkt_beats} !== {1'b1, 16'd1}) begin
            $display("[TB] FAIL single_beat: got %h expected %h", {pkt_done, last_pkt_beats}, {1'b1, 16'd1});
        end else n_pass++;
        step();
    endtask

    task automatic test_reset_mid_packet();
        drive(3, 1'b1, 32'h300, 1'b0);
        mid();
        step();
        mid();
        n_checks++;
        if ({grant_valid, grant_idx} !== {1'b1, 2'd3}) begin
            $display("[TB] FAIL rst_pre_grant: got %b expected %b", {grant_valid, grant_idx}, {1'b1, 2'd3});
        end else n_pass++;
        step();
        drive(3, 1'b1, 32'h301, 1'b0);
        mid();
        #2;
        aresetn = 1'b0;
        #1;
        n_checks++;
        if ({s_tready, m_tvalid, grant_valid, pkt_done, last_pkt_beats} !== 23'h0) begin
            $display("[TB] FAIL rst_immediate: got %h expected %h",
                     {s_tready, m_tvalid, grant_valid, pkt_done, last_pkt_beats}, 23'h0);
        end else n_pass++;
        step();
        aresetn = 1'b1;
        drive(3, 1'b1, 32'h300, 1'b0);
        drive(0, 1'b1, 32'hAA, 1'b1);
        mid();
        n_checks++;
        if (grant_valid !== 1'b0) begin
            $display("[TB] FAIL rst_bubble: got %b expected 0", grant_valid);
        end else n_pass++;
        step();
        mid();
        n_checks++;
        if ({grant_valid, grant_idx} !== {1'b1, 2'd0}) begin
            $display("[TB] FAIL rst_restart: got %b expected %b", {grant_valid, grant_idx}, {1'b1, 2'd0});
        end else n_pass++;
        step();
        s_tvalid = '0;
        step();
    endtask

    initial begin
        aresetn  = 1'b0;
        m_tready = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        s_tkeep  = '1;
        s_tstrb  = '1;
        s_tid    = {8'h03, 8'h02, 8'h01, 8'h00};
        s_tdest  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        s_tuser  = 4'b0100;
        #2;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_valid_gap();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares one AXI-Stream sink (the tx side of clock_crossing_fifo) among NUM_SRC AXI-Stream sources, all in the tx clock domain.
- A grant is held from the first beat of a packet through its tlast beat, so packets never interleave.
- Sits directly in front of the FIFO tx port; reports the current owner and per-packet beat counts for debug.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8)
- DATA_W, 32, tdata width; KEEP_W = DATA_W/8 is derived
- ID_W, 8, tid width
- DEST_W, 8, tdest width
- USER_W, 1, tuser width
- CNT_W, 16, width of the beat counter; saturates at all-ones

Ports:
- aclk  in  1  clock, shared with the FIFO tx side
- aresetn  in  1  asynchronous active-low reset
- s_tvalid  in  NUM_SRC  per-source valid
- s_tready  out  NUM_SRC  per-source ready
- s_tdata  in  NUM_SRC*DATA_W  source data, source i at slice [i*DATA_W +: DATA_W]
- s_tkeep, s_tstrb  in  NUM_SRC*KEEP_W  byte qualifiers
- s_tlast  in  NUM_SRC  end of packet
- s_tid, s_tdest, s_tuser  in  NUM_SRC*ID_W / NUM_SRC*DEST_W / NUM_SRC*USER_W  sideband
- m_tvalid, m_tready, m_tdata, m_tkeep, m_tstrb, m_tlast, m_tid, m_tdest, m_tuser  out/in  per widths  single master stream to the FIFO tx port
- grant_valid  out  1  a source currently owns m_*
- grant_idx  out  $clog2(NUM_SRC)  owning source index
- last_pkt_beats  out  CNT_W  beat count of the most recently completed packet
- pkt_done  out  1  one-cycle pulse when a tlast beat is accepted on m_*

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant_valid=0, grant_idx=0, s_tready=0, m_tvalid=0, pkt_done=0, last_pkt_beats=0, beat_cnt=0, rr_last=NUM_SRC-1 (the first search starts at source 0).
- FSM IDLE:
  - If any s_tvalid is high, select the first requesting index searching rr_last+1, rr_last+2, ... modulo NUM_SRC.
  - Register it into grant_idx, set grant_valid=1, go to PASS.
  - Otherwise stay in IDLE.
  - The decision is registered, so there is one bubble cycle between a request and its first transfer.
- FSM PASS:
  - Combinational mux: m_* = source grant_idx fields; m_tvalid = s_tvalid[grant_idx].
  - s_tready[grant_idx] = m_tready; all other s_tready = 0.
  - Each m_tvalid && m_tready increments beat_cnt (saturating).
  - On a handshake with m_tlast=1: last_pkt_beats = beat_cnt+1 (saturating), pkt_done=1 next cycle, beat_cnt=0, rr_last=grant_idx, grant_valid=0, go to IDLE.
- m_tvalid and s_tready are 0 in IDLE; m_* data is don't-care when m_tvalid=0.
- The owning source may drop s_tvalid mid-packet; the grant is held until tlast (no timeout).
- Backpressure: if m_tready=0 (FIFO full), the handshake stalls and the grant and beat_cnt hold.
- Single-beat packet (tvalid with tlast on the first beat): one transfer, then IDLE; the next grant goes to the next requester.
- Wrap-around: the search wraps from NUM_SRC-1 to 0. A lone requester is re-granted after every packet with one idle cycle between packets.
- A request that changes while in IDLE takes effect at the next clock edge; no combinational path from s_tvalid to grant.
- Reset asserted mid-packet: all outputs return to reset values immediately. A partial packet already in the FIFO is the consumer's concern.

Decomposition:
- Package axis_arb_pkg: state enum (IDLE, PASS), IDX_W = $clog2(NUM_SRC) helper function, default width constants.
- Sub-module rr_pick: combinational round-robin priority selector with inputs req[NUM_SRC] and last[IDX_W], and outputs idx and any.
- The top level holds the FSM, counters and the mux.

Test Plan:
- Reset release with all s_tvalid=0: m_tvalid=0, s_tready=0, grant_valid=0 for 20 cycles.
- Source 0 sends a 4-beat packet 0x42..0x45 (tlast on 0x45) with m_tready=1: grant_idx=0 one cycle after tvalid; m_tdata shows 0x42,0x43,0x44,0x45 on consecutive cycles; pkt_done pulses; last_pkt_beats=4.
- Sources 0, 1 and 3 request simultaneously with 2-beat packets: grant order 0,1,3; no interleaving; then source 0 re-requests and is granted after 3.
- Source 2 sends 0xDEADBEEF,0x1,0x2 with m_tready low for 5 cycles after beat 1: beat 2 holds on m_tdata, grant stays 2, beat count ends at 3.
- Source 1 drops tvalid for 3 cycles mid-packet while source 0 requests: grant stays 1 until tlast; then source 0 is granted.
- Assert aresetn low during beat 2 of a packet: s_tready, m_tvalid and grant_valid are 0 within the same cycle; after release, arbitration restarts from source 0.
